// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared widths and helpers for the register scoreboard
package reg_scoreboard_pkg;

    localparam int NUM_RF  = 16;
    localparam int NUM_VRF = 64;
    localparam int RID_W   = 4;
    localparam int VID_W   = 6;
    localparam int CNT_W   = 2;
    localparam int PEND_W  = 8;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    // Total in-flight count moves by up to three each way per cycle and clamps at both ends.
    function automatic logic [PEND_W-1:0] pending_next(
        input logic [PEND_W-1:0] pend,
        input logic [1:0]        ups,
        input logic [1:0]        downs
    );
        int sum;
        sum = int'(pend) + int'(ups) - int'(downs);
        if (sum < 0)
            return '0;
        else if (sum > int'(PEND_MAX))
            return PEND_MAX;
        else
            return PEND_W'(sum);
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter_bank.sv
// rtl/reg_scoreboard_sb_counter_bank.sv - bank of saturating up/down pending-write counters
module sb_counter_bank #(
    parameter int N     = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic             dec,
    input  logic [IDX_W-1:0] dec_idx,
    input  logic [IDX_W-1:0] rd_a_idx,
    input  logic [IDX_W-1:0] rd_b_idx,
    output logic             nz_a,
    output logic             nz_b,
    output logic             full,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt [N];

    assign nz_a = (cnt[rd_a_idx] != '0);
    assign nz_b = (cnt[rd_b_idx] != '0);
    assign full = (cnt[inc_idx] == MAX);

    // A retire matched by an issue to the same register in one cycle nets to zero and is not an underflow.
    assign underflow = en & dec & (cnt[dec_idx] == '0) & ~(inc & (inc_idx == dec_idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                cnt[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < N; i++) begin
                if (inc && (inc_idx == IDX_W'(i)) && !(dec && (dec_idx == IDX_W'(i)))) begin
                    if (cnt[i] != MAX)
                        cnt[i] <= cnt[i] + 1'b1;
                end else if (dec && (dec_idx == IDX_W'(i)) && !(inc && (inc_idx == IDX_W'(i)))) begin
                    if (cnt[i] != '0)
                        cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - decode-stage issue controller tracking in-flight scalar, vector and CC writes
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic             I_CLOCK,
    input  logic             I_RESET_N,
    input  logic             I_LOCK,
    input  logic             I_Issue_Valid,
    input  logic [RID_W-1:0] I_Src1Idx,
    input  logic [RID_W-1:0] I_Src2Idx,
    input  logic             I_Src1Use,
    input  logic             I_Src2Use,
    input  logic [VID_W-1:0] I_VSrc1Idx,
    input  logic [VID_W-1:0] I_VSrc2Idx,
    input  logic             I_VSrc1Use,
    input  logic             I_VSrc2Use,
    input  logic [RID_W-1:0] I_DestIdx,
    input  logic             I_DestWrite,
    input  logic [VID_W-1:0] I_VDestIdx,
    input  logic             I_VDestWrite,
    input  logic             I_CCRead,
    input  logic             I_CCWrite,
    input  logic             I_Flush,
    input  logic             I_WB_RegWEn,
    input  logic [RID_W-1:0] I_WB_RegIdx,
    input  logic             I_WB_VRegWEn,
    input  logic [VID_W-1:0] I_WB_VRegIdx,
    input  logic             I_WB_CCWEn,
    output logic             O_Issue_Ready,
    output logic             O_DepStallSignal,
    output logic [7:0]       O_Pending,
    output logic             O_Underflow
);

    logic             rf_nz_a, rf_nz_b, rf_full, rf_uf;
    logic             vrf_nz_a, vrf_nz_b, vrf_full, vrf_uf;
    logic [CNT_W-1:0] cc_cnt;
    logic             raw, sat, fire;
    logic             cc_up, cc_dn, cc_uf;
    logic [1:0]       ups, downs;

    sb_counter_bank #(.N(NUM_RF), .IDX_W(RID_W), .CNT_W(CNT_W)) u_rf_bank (
        .clk       (I_CLOCK),
        .rst_n     (I_RESET_N),
        .en        (I_LOCK),
        .inc       (fire & I_DestWrite),
        .inc_idx   (I_DestIdx),
        .dec       (I_WB_RegWEn),
        .dec_idx   (I_WB_RegIdx),
        .rd_a_idx  (I_Src1Idx),
        .rd_b_idx  (I_Src2Idx),
        .nz_a      (rf_nz_a),
        .nz_b      (rf_nz_b),
        .full      (rf_full),
        .underflow (rf_uf)
    );

    sb_counter_bank #(.N(NUM_VRF), .IDX_W(VID_W), .CNT_W(CNT_W)) u_vrf_bank (
        .clk       (I_CLOCK),
        .rst_n     (I_RESET_N),
        .en        (I_LOCK),
        .inc       (fire & I_VDestWrite),
        .inc_idx   (I_VDestIdx),
        .dec       (I_WB_VRegWEn),
        .dec_idx   (I_WB_VRegIdx),
        .rd_a_idx  (I_VSrc1Idx),
        .rd_b_idx  (I_VSrc2Idx),
        .nz_a      (vrf_nz_a),
        .nz_b      (vrf_nz_b),
        .full      (vrf_full),
        .underflow (vrf_uf)
    );

    // Hazards look only at registered counts, so a same-cycle writeback never lifts a stall early.
    assign raw = (I_Src1Use & rf_nz_a) | (I_Src2Use & rf_nz_b)
               | (I_VSrc1Use & vrf_nz_a) | (I_VSrc2Use & vrf_nz_b)
               | (I_CCRead & (cc_cnt != '0));
    assign sat = (I_DestWrite & rf_full) | (I_VDestWrite & vrf_full)
               | (I_CCWrite & (cc_cnt == CNT_MAX));

    assign O_Issue_Ready    = I_LOCK & ~raw & ~sat;
    assign fire             = I_Issue_Valid & O_Issue_Ready & ~I_Flush;
    assign O_DepStallSignal = I_Issue_Valid & ~O_Issue_Ready & ~I_Flush;

    assign cc_up = fire & I_CCWrite;
    assign cc_dn = I_LOCK & I_WB_CCWEn;
    assign cc_uf = cc_dn & ~cc_up & (cc_cnt == '0);

    assign ups   = {1'b0, fire & I_DestWrite} + {1'b0, fire & I_VDestWrite} + {1'b0, cc_up};
    assign downs = {1'b0, I_LOCK & I_WB_RegWEn} + {1'b0, I_LOCK & I_WB_VRegWEn} + {1'b0, cc_dn};

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            cc_cnt      <= '0;
            O_Pending   <= '0;
            O_Underflow <= 1'b0;
        end else if (I_LOCK) begin
            if (cc_up && !cc_dn && cc_cnt != CNT_MAX)
                cc_cnt <= cc_cnt + 1'b1;
            else if (cc_dn && !cc_up && cc_cnt != '0)
                cc_cnt <= cc_cnt - 1'b1;
            O_Pending   <= pending_next(O_Pending, ups, downs);
            O_Underflow <= O_Underflow | rf_uf | vrf_uf | cc_uf;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - randomized and directed checks of reg_scoreboard against a behavioural model
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lock, valid, use1, use2, vuse1, vuse2, dw, vdw, ccr, ccw, flush;
    logic       wb_r, wb_v, wb_cc;
    logic [3:0] src1, src2, dst, wb_ridx;
    logic [5:0] vsrc1, vsrc2, vdst, wb_vidx;
    logic       ready, stall, underflow;
    logic [7:0] pending;

    int  m_rf [16];
    int  m_vrf [64];
    int  m_cc, m_pend;
    bit  m_uf;
    int  vectors = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(lock), .I_Issue_Valid(valid),
        .I_Src1Idx(src1), .I_Src2Idx(src2), .I_Src1Use(use1), .I_Src2Use(use2),
        .I_VSrc1Idx(vsrc1), .I_VSrc2Idx(vsrc2), .I_VSrc1Use(vuse1), .I_VSrc2Use(vuse2),
        .I_DestIdx(dst), .I_DestWrite(dw), .I_VDestIdx(vdst), .I_VDestWrite(vdw),
        .I_CCRead(ccr), .I_CCWrite(ccw), .I_Flush(flush),
        .I_WB_RegWEn(wb_r), .I_WB_RegIdx(wb_ridx), .I_WB_VRegWEn(wb_v), .I_WB_VRegIdx(wb_vidx),
        .I_WB_CCWEn(wb_cc),
        .O_Issue_Ready(ready), .O_DepStallSignal(stall), .O_Pending(pending), .O_Underflow(underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        lock = 1'b1; valid = 1'b0; use1 = 1'b0; use2 = 1'b0; vuse1 = 1'b0; vuse2 = 1'b0;
        dw = 1'b0; vdw = 1'b0; ccr = 1'b0; ccw = 1'b0; flush = 1'b0;
        wb_r = 1'b0; wb_v = 1'b0; wb_cc = 1'b0;
        src1 = '0; src2 = '0; dst = '0; wb_ridx = '0;
        vsrc1 = '0; vsrc2 = '0; vdst = '0; wb_vidx = '0;
    endtask

    task automatic model_reset();
        foreach (m_rf[i]) m_rf[i] = 0;
        foreach (m_vrf[i]) m_vrf[i] = 0;
        m_cc = 0; m_pend = 0; m_uf = 1'b0;
    endtask

    function automatic bit m_ready();
        bit hazard;
        hazard = (use1 && m_rf[src1] != 0) || (use2 && m_rf[src2] != 0)
              || (vuse1 && m_vrf[vsrc1] != 0) || (vuse2 && m_vrf[vsrc2] != 0)
              || (ccr && m_cc != 0)
              || (dw && m_rf[dst] == 3) || (vdw && m_vrf[vdst] == 3) || (ccw && m_cc == 3);
        return lock && !hazard;
    endfunction

    // Retire after issue: an issue and retire of the same register cancel without flagging.
    task automatic retire(inout int c);
        if (c == 0) m_uf = 1'b1;
        else c = c - 1;
    endtask

    task automatic model_clock();
        bit fire;
        int ups, downs;
        if (!lock) return;
        fire = valid && m_ready() && !flush;
        ups = 0; downs = 0;
        if (fire && dw)  begin m_rf[dst]++;   ups++; end
        if (fire && vdw) begin m_vrf[vdst]++; ups++; end
        if (fire && ccw) begin m_cc++;        ups++; end
        if (wb_r)  begin retire(m_rf[wb_ridx]);  downs++; end
        if (wb_v)  begin retire(m_vrf[wb_vidx]); downs++; end
        if (wb_cc) begin retire(m_cc);           downs++; end
        m_pend = m_pend + ups - downs;
        if (m_pend < 0) m_pend = 0;
        if (m_pend > 255) m_pend = 255;
    endtask

    // Inputs are applied just after a posedge; outputs are sampled mid-cycle.
    task automatic cycle(input string tag, input int exp_ready);
        bit r;
        #3;
        r = m_ready();
        if (exp_ready >= 0) check({tag, ".spec_ready"}, ready, exp_ready);
        check({tag, ".ready"}, ready, r);
        check({tag, ".stall"}, stall, valid && !r && !flush);
        check({tag, ".pending"}, pending, m_pend);
        check({tag, ".underflow"}, underflow, m_uf);
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        do_reset();

        // Reset state: free source issues immediately.
        valid = 1'b1; use1 = 1'b1; src1 = 4'd3;
        cycle("t1", 1);

        // RAW on scalar register, no same-cycle bypass.
        do_reset();
        valid = 1'b1; dw = 1'b1; dst = 4'd2;
        cycle("t2_issue", 1);
        dw = 1'b0; use1 = 1'b1; src1 = 4'd2;
        cycle("t2_raw", 0);
        wb_r = 1'b1; wb_ridx = 4'd2;
        cycle("t2_wb", 0);
        wb_r = 1'b0;
        cycle("t2_free", 1);

        // Saturation of a scalar counter at three in flight.
        do_reset();
        valid = 1'b1; dw = 1'b1; dst = 4'd5;
        for (int i = 0; i < 3; i++) cycle("t3_fill", 1);
        cycle("t3_sat", 0);
        wb_r = 1'b1; wb_ridx = 4'd5;
        cycle("t3_wb", 0);
        wb_r = 1'b0;
        cycle("t3_go", 1);

        // Same-cycle issue and retire of a vector register.
        do_reset();
        valid = 1'b1; vdw = 1'b1; vdst = 6'd10;
        cycle("t4_first", 1);
        wb_v = 1'b1; wb_vidx = 6'd10;
        cycle("t4_net", 1);
        wb_v = 1'b0; vdw = 1'b0; vuse1 = 1'b1; vsrc1 = 6'd10;
        cycle("t4_reader", 0);
        check("t4_no_uf", underflow, 0);

        // Condition-code dependence and flush.
        do_reset();
        valid = 1'b1; ccw = 1'b1;
        cycle("t5_cmp", 1);
        ccw = 1'b0; ccr = 1'b1;
        cycle("t5_brz", 0);
        flush = 1'b1;
        cycle("t5_flush", 0);
        flush = 1'b0; wb_cc = 1'b1;
        cycle("t5_wb", 0);
        wb_cc = 1'b0;
        cycle("t5_go", 1);
        valid = 1'b0; ccr = 1'b0;
        cycle("t5_idle", -1);

        // Sticky underflow, then asynchronous reset mid-cycle.
        do_reset();
        valid = 1'b1; dw = 1'b1; dst = 4'd7;
        cycle("t6_issue", 1);
        dw = 1'b0; valid = 1'b0; wb_r = 1'b1; wb_ridx = 4'd1;
        cycle("t6_uf", -1);
        wb_r = 1'b0; valid = 1'b1; use1 = 1'b1; src1 = 4'd7;
        cycle("t6_sticky", 0);
        check("t6_sticky_flag", underflow, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_uf", underflow, 0);
        check("t6_async_pend", pending, 0);
        check("t6_async_ready", ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic with a small register window to provoke hazards.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int ri, vi;
            lock  = ($urandom % 8) != 0;
            valid = $urandom % 2;
            use1  = $urandom % 2; src1  = 4'($urandom % 4);
            use2  = $urandom % 2; src2  = 4'($urandom % 4);
            vuse1 = $urandom % 2; vsrc1 = 6'($urandom % 4);
            vuse2 = $urandom % 2; vsrc2 = 6'($urandom % 4);
            dw    = $urandom % 2; dst   = 4'($urandom % 4);
            vdw   = $urandom % 2; vdst  = 6'($urandom % 4);
            ccr   = ($urandom % 4) == 0;
            ccw   = ($urandom % 4) == 0;
            flush = ($urandom % 6) == 0;
            ri = $urandom % 4; vi = $urandom % 4;
            wb_ridx = 4'(ri); wb_vidx = 6'(vi);
            wb_r  = (m_rf[ri] != 0) && ($urandom % 2);
            wb_v  = (m_vrf[vi] != 0) && ($urandom % 2);
            wb_cc = (m_cc != 0) && ($urandom % 2);
            cycle("rand", -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
